pipelined_prefix_adder: RTL and testbench
=========================================

Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined N-bit parallel-prefix (Kogge-Stone style) adder/subtractor with valid/ready handshakes on both sides.
- Successor to the team's combinational prefix adder. Adds:
  - a configurable number of register stages splitting the prefix tree;
  - add/subtract mode;
  - carry, overflow and zero flags;
  - a sideband tag;
  - full backpressure.
- Sits between the ALU operand mux and the writeback stage.

Parameters:
- N, 32, operand width; any value ≥ 2.
- STAGES, 3, pipeline register stages; legal range 1..$clog2(N)+1; out-of-range fails elaboration.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operation valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in. Ignored in subtract mode.
- sub  input  1  0 = a+b+cin; 1 = a−b, computed as a+~b+1.
- in_tag  input  TAG_W  sideband, returned unmodified.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  N  result, modulo 2^N.
- cout  output  1  carry-out of bit N−1. For subtract, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.
- out_tag  output  TAG_W  tag of the presented result.

Behaviour:
- Reset:
  - Asynchronous assert clears every stage valid bit.
  - After reset: out_valid=0; sum, cout, ovf and zero = 0; out_tag=0; in_ready=1.
  - Data registers other than the output stage need not reset.
  - Deassertion is taken synchronously to clk by the surrounding logic. The block samples no input in the cycle rst_n rises.
- Stage 0 (input stage) registers the generate/propagate vector G0/P0 from a and b (b inverted when sub=1), plus the carry-in. The effective carry-in is 1 when sub=1, otherwise cin.
- Prefix levels:
  - The $clog2(N) prefix levels, plus the final sum/flag XOR, are partitioned across STAGES registers.
  - Levels are divided as evenly as possible; earlier stages take the extra level.
  - STAGES=1 means fully combinational up to the single output register.
- Latency is exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls.
- Throughput is 1 operation per cycle when out_ready is held high.
- Handshake:
  - Transfer occurs on a clock edge where valid & ready are both high.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready=1 or out_valid=0.
  - in_ready = stage 0 empty or stage 0 advancing. It is purely combinational from stage state and out_ready; there is no path from in_valid.
  - Bubbles collapse: an empty stage always accepts from the stage behind it, even when the output is stalled.
- While out_valid=1 and out_ready=0: sum, cout, ovf, zero and out_tag hold stable.
- Ordering is strictly in order. Each tag stays paired with its own result.
- Arithmetic:
  - In subtract mode, cout=1 iff a ≥ b (unsigned).
  - ovf is computed identically for add and subtract.
  - Outputs are a pure function of the operands; no accumulation between operations.
- Boundary cases:
  - Pipeline full with out_ready=0: in_ready=0. Inputs offered are not accepted and not corrupted.
  - Simultaneous output pop and input push when full: both occur in the same cycle, and occupancy is unchanged.
  - Reset mid-operation: all in-flight operations are discarded and no stale out_valid appears afterwards.
  - in_valid held high with changing data while in_ready=0 is legal. Only data present at the accepting edge is used.

Test Plan:
- N=32, STAGES=3, out_ready=1. Apply a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, tag=5 at cycle 0 -> cycle 3: sum=0, cout=1, ovf=0, zero=1, out_tag=5.
- a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1. Then a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0.
- Back-to-back stream of 100 random ops, out_ready=1 -> one result per cycle; every result matches the reference model; tags arrive in order.
- Backpressure: fill the pipe with out_ready=0, then randomly toggle out_ready (50%) for 200 ops -> in_ready drops only when 3 ops are held; outputs stable while stalled; no loss or duplication.
- Assert rst_n low asynchronously (mid-cycle) with 2 ops in flight -> out_valid=0 immediately; no in-flight result emerges after release. The first new op returns after exactly 3 cycles.
- Parameter sweep over N∈{2,8,33,64}, STAGES∈{1, $clog2(N)+1}, 1000 random ops each -> all results match the model; latency equals STAGES.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: Kogge-Stone adder/subtractor whose prefix levels are split across STAGES
// handshaked register stages; valid/ready on both sides with collapsing bubbles.
module pipelined_prefix_adder #(
    parameter int N = 32,
    parameter int STAGES = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int L = $clog2(N);
    localparam int T = L + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             ci;
        logic [N-1:0]     p0;
        logic [N-1:0]     g;
        logic [N-1:0]     p;
    } st_t;

    // Work unit u (0 = G0/P0, 1..L = prefix levels, L+1 = sum/flags) -> owning stage; earlier stages take the extra unit.
    function automatic int stage_of(input int u);
        int acc;
        stage_of = 0;
        acc = 0;
        for (int k = 0; k < STAGES; k++) begin
            acc += T / STAGES + ((k < T % STAGES) ? 1 : 0);
            if (u > acc) stage_of = k + 1;
        end
    endfunction

    if (N < 2 || STAGES < 1 || STAGES > T) begin : g_bad_param
        $error("pipelined_prefix_adder: N must be >= 2 and STAGES in 1..$clog2(N)+1");
    end

    logic [STAGES-1:0] vld, adv, vprev;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign adv[k] = out_ready | ~(&vld[STAGES-1:k]);
        if (k == 0) begin : g_first
            assign vprev[k] = in_valid;
        end else begin : g_next
            assign vprev[k] = vld[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld <= '0;
        else vld <= (vprev & adv) | (vld & ~adv);
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];

    st_t x [L+1];
    st_t y [L+1];

    for (genvar u = 0; u <= L; u++) begin : g_unit
        st_t s;
        if (u == 0) begin : g_gen
            logic [N-1:0] bb;
            assign bb = sub ? ~b : b;
            // Carry-in is folded into g[0] so every prefix g[i] is the true carry out of bit i.
            always_comb begin
                s.tag = in_tag;
                s.ci  = sub | cin;
                s.p0  = a ^ bb;
                s.p   = a ^ bb;
                s.g   = a & bb;
                s.g[0] = s.g[0] | (s.p0[0] & s.ci);
            end
        end else begin : g_lvl
            localparam int D = 1 << (u - 1);
            always_comb begin
                s = y[u-1];
                for (int i = D; i < N; i++) begin
                    s.g[i] = y[u-1].g[i] | (y[u-1].p[i] & y[u-1].g[i-D]);
                    s.p[i] = y[u-1].p[i] & y[u-1].p[i-D];
                end
            end
        end
        assign x[u] = s;
        if (stage_of(u + 1) != stage_of(u)) begin : g_reg
            st_t r;
            always_ff @(posedge clk) begin
                if (adv[stage_of(u)]) r <= x[u];
            end
            assign y[u] = r;
        end else begin : g_thru
            assign y[u] = x[u];
        end
    end

    st_t f;
    logic [N-1:0] fs;
    assign f  = y[L];
    assign fs = f.p0 ^ {f.g[N-2:0], f.ci};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            out_tag <= '0;
        end else if (adv[STAGES-1]) begin
            sum     <= fs;
            cout    <= f.g[N-1];
            ovf     <= f.g[N-1] ^ f.g[N-2];
            zero    <= ~|fs;
            out_tag <= f.tag;
        end
    end
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: scoreboarded random test of several N/STAGES configurations
// against an integer-arithmetic reference model, with backpressure and mid-flight reset.
module tb_pipelined_prefix_adder;
    logic clk = 0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    localparam int NC = 9;
    logic [NC-1:0] done = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_n(input int i);
        case (i)
            0: cfg_n = 32;
            1, 2: cfg_n = 2;
            3, 4: cfg_n = 8;
            5, 6: cfg_n = 33;
            default: cfg_n = 64;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: cfg_s = 3;
            2: cfg_s = 2;
            4: cfg_s = 4;
            6, 8: cfg_s = 7;
            default: cfg_s = 1;
        endcase
    endfunction

    for (genvar i = 0; i < NC; i++) begin : g_cfg
        localparam int NN = cfg_n(i);
        localparam int SS = cfg_s(i);

        typedef struct packed {
            logic [3:0]    tag;
            logic          z;
            logic          o;
            logic          c;
            logic [NN-1:0] s;
            int            t;
            bit            lat;
        } ex_t;

        logic rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
        logic [NN-1:0] a, b, sum;
        logic [3:0] in_tag, out_tag;
        ex_t q[$];
        int occ = 0;
        int mode = 0;
        bit pv = 0;
        logic [NN+7:0] pvals;

        pipelined_prefix_adder #(.N(NN), .STAGES(SS), .TAG_W(4)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .cin(cin), .sub(sub), .in_tag(in_tag),
            .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
            .ovf(ovf), .zero(zero), .out_tag(out_tag)
        );

        // Reference: wide unsigned sum for result/carry, sign-extended sum range check for overflow.
        function automatic ex_t model(input logic [NN-1:0] x, input logic [NN-1:0] y,
                                      input logic ci, input logic sb, input logic [3:0] tg);
            ex_t e;
            logic [NN:0] w;
            logic signed [NN+1:0] sw;
            if (sb) begin
                w = {1'b0, x} - {1'b0, y};
                e.c = (x >= y);
                sw = $signed({x[NN-1], x[NN-1], x}) - $signed({y[NN-1], y[NN-1], y});
            end else begin
                w = {1'b0, x} + {1'b0, y} + (NN+1)'(ci);
                e.c = w[NN];
                sw = $signed({x[NN-1], x[NN-1], x}) + $signed({y[NN-1], y[NN-1], y})
                   + $signed({{(NN+1){1'b0}}, ci});
            end
            e.s = w[NN-1:0];
            e.z = (e.s == '0);
            e.o = (sw[NN+1:NN-1] != 3'b000) && (sw[NN+1:NN-1] != 3'b111);
            e.tag = tg;
            e.t = 0;
            e.lat = 0;
            return e;
        endfunction

        task automatic step();
            @(posedge clk);
            #1;
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(1));
        endtask

        task automatic rand_in();
            int r;
            r = $urandom_range(7);
            a = (r == 0) ? '1 : (r == 1) ? '0 : NN'({$urandom(), $urandom()});
            r = $urandom_range(7);
            b = (r == 0) ? '1 : (r == 1) ? '0 : NN'({$urandom(), $urandom()});
            cin = 1'($urandom);
            sub = 1'($urandom);
            in_tag = 4'($urandom);
        endtask

        task automatic offer(input bit rnd);
            ex_t e;
            in_valid = 1;
            for (int w = 0; w < 300; w++) begin
                @(negedge clk);
                if (in_ready) begin
                    e = model(a, b, cin, sub, in_tag);
                    e.t = cyc;
                    e.lat = (mode == 0);
                    q.push_back(e);
                    step();
                    in_valid = 0;
                    return;
                end
                step();
                if (rnd) rand_in();
            end
            total++;
            bad++;
            $display("FAIL cfg%0d accept_timeout in_ready=%b required 1", i, in_ready);
            in_valid = 0;
        endtask

        task automatic drain();
            in_valid = 0;
            for (int w = 0; w < 200 && q.size() != 0; w++) step();
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL cfg%0d drain pending=%0d required 0", i, q.size());
            end
        endtask

        initial begin : drv
            rst_n = 0;
            in_valid = 0;
            out_ready = 1;
            rand_in();
            repeat (3) @(posedge clk);
            #2 rst_n = 1;
            step();
            a = '1; b = 1; cin = 0; sub = 0; in_tag = 5; offer(0);
            a = {NN{1'b1}} >> 1; b = 1; in_tag = 6; offer(0);
            a = NN'(5); b = NN'(7); cin = 1; sub = 1; in_tag = 7; offer(0);
            a = '0; b = '0; cin = 0; sub = 1; in_tag = 8; offer(0);
            a = '0; b = '0; cin = 1; sub = 0; in_tag = 9; offer(0);
            drain();
            repeat (100) begin rand_in(); offer(0); end
            drain();
            mode = 1;
            step();
            repeat (SS) begin rand_in(); offer(1); end
            mode = 2;
            repeat (200) begin rand_in(); offer(1); end
            mode = 0;
            drain();
            rand_in(); offer(0);
            rand_in(); offer(0);
            #2 rst_n = 0;
            #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || {sum, cout, ovf, zero, out_tag} !== '0) begin
                bad++;
                $display("FAIL cfg%0d async_reset out_valid=%b in_ready=%b outs=%h required 0 1 0",
                         i, out_valid, in_ready, {sum, cout, ovf, zero, out_tag});
            end
            q.delete();
            @(posedge clk);
            #2 rst_n = 1;
            step();
            a = NN'(5); b = NN'(7); cin = 0; sub = 1; in_tag = 10; offer(0);
            drain();
            for (int n = 0; n < 1000; n++) begin
                if (n == 500) begin drain(); mode = 2; end
                if ($urandom_range(3) == 0) begin in_valid = 0; rand_in(); step(); end
                rand_in();
                offer(n >= 500);
            end
            mode = 0;
            drain();
            done[i] = 1'b1;
        end

        always @(negedge clk) begin : mon
            ex_t e;
            if (!rst_n) begin
                occ = 0;
                pv = 0;
            end else begin
                if (pv) begin
                    total++;
                    if ({out_valid, sum, cout, ovf, zero, out_tag} !== pvals) begin
                        bad++;
                        $display("FAIL cfg%0d stall_hold got=%h required=%h", i,
                                 {out_valid, sum, cout, ovf, zero, out_tag}, pvals);
                    end
                end
                total++;
                if (in_ready !== !(occ == SS && !out_ready)) begin
                    bad++;
                    $display("FAIL cfg%0d in_ready got=%b required=%b occ=%0d", i, in_ready,
                             !(occ == SS && !out_ready), occ);
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL cfg%0d unexpected_output sum=%h tag=%h required none", i, sum, out_tag);
                    end else begin
                        e = q.pop_front();
                        if ({sum, cout, ovf, zero, out_tag} !== {e.s, e.c, e.o, e.z, e.tag}) begin
                            bad++;
                            $display("FAIL cfg%0d result got sum=%h c=%b o=%b z=%b tag=%h required sum=%h c=%b o=%b z=%b tag=%h",
                                     i, sum, cout, ovf, zero, out_tag, e.s, e.c, e.o, e.z, e.tag);
                        end
                        if (e.lat) begin
                            total++;
                            if (cyc - e.t != SS) begin
                                bad++;
                                $display("FAIL cfg%0d latency got=%0d required=%0d", i, cyc - e.t, SS);
                            end
                        end
                    end
                end
                occ += int'(in_valid && in_ready) - int'(out_valid && out_ready);
                pv = out_valid && !out_ready;
                pvals = {out_valid, sum, cout, ovf, zero, out_tag};
            end
        end
    end

    initial begin
        for (int c = 0; c < 80000 && done != '1; c++) @(posedge clk);
        if (done != '1) begin
            total++;
            bad++;
            $display("FAIL run_timeout done=%b required all ones", done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
